// File: rtl/reg_bank_fwd_if.sv
// reg_bank_fwd_if: operand-fetch bus between the pipeline and reg_bank_fwd.
//   master modport (pipeline side):
//     drives ra, rb, rw, wdata, we, stall, ans_ex, ans_dm, ans_wb, imm,
//     mux_sel_a, mux_sel_b, imm_sel
//     samples a, b, rd_valid
//   slave modport (register bank side): the same signals in the opposite directions.
//   Parameters DATA_W / ADDR_W must match the reg_bank_fwd instance on the bus.
interface reg_bank_fwd_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] rw;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              stall;
  logic [DATA_W-1:0] ans_ex;
  logic [DATA_W-1:0] ans_dm;
  logic [DATA_W-1:0] ans_wb;
  logic [DATA_W-1:0] imm;
  logic [1:0]        mux_sel_a;
  logic [1:0]        mux_sel_b;
  logic              imm_sel;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              rd_valid;

  modport master (
    output ra, rb, rw, wdata, we, stall, ans_ex, ans_dm, ans_wb, imm,
           mux_sel_a, mux_sel_b, imm_sel,
    input  a, b, rd_valid
  );

  modport slave (
    input  ra, rb, rw, wdata, we, stall, ans_ex, ans_dm, ans_wb, imm,
           mux_sel_a, mux_sel_b, imm_sel,
    output a, b, rd_valid
  );
endinterface

// File: rtl/reg_bank_fwd.sv
// reg_bank_fwd: 2-read / 1-write register bank with latched read ports and
// combinational operand forwarding muxes.
//   clk  : single clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset (clears array, latches, rd_valid)
//   bus  : reg_bank_fwd_if.slave
//          ra/rb read addresses, rw/wdata/we write port, stall holds latches,
//          ans_ex/ans_dm/ans_wb forwarding sources, imm immediate,
//          mux_sel_a/mux_sel_b (00 latch, 01 ex, 10 dm, 11 wb), imm_sel,
//          a/b operands (combinational), rd_valid (registered)
// Build option: define WRITE_BYPASS_EN to make a same-edge read of the write
// address latch the incoming wdata instead of the old array contents.
module reg_bank_fwd #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  reg_bank_fwd_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ar;
  logic [DATA_W-1:0] br;
  logic              rd_valid_q;
  logic              wr_en_c;
  logic [DATA_W-1:0] ra_data_c;
  logic [DATA_W-1:0] rb_data_c;

  // Entry 0 is never written, so it stays at its reset value of 0.
  assign wr_en_c = bus.we && (bus.rw != '0);

  // Read data presented to the latches.
  always_comb begin
    ra_data_c = mem[bus.ra];
    rb_data_c = mem[bus.rb];
`ifdef WRITE_BYPASS_EN
    if (wr_en_c && (bus.ra == bus.rw)) ra_data_c = bus.wdata;
    if (wr_en_c && (bus.rb == bus.rw)) rb_data_c = bus.wdata;
`endif
  end

  // Register array; writes proceed regardless of stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en_c) begin
      mem[bus.rw] <= bus.wdata;
    end
  end

  // Read latches and valid flag, frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar         <= '0;
      br         <= '0;
      rd_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      ar         <= ra_data_c;
      br         <= rb_data_c;
      rd_valid_q <= 1'b1;
    end
  end

  // Forwarding muxes act in the same cycle as their selects.
  always_comb begin
    bus.a = ar;
    unique case (bus.mux_sel_a)
      2'b01:   bus.a = bus.ans_ex;
      2'b10:   bus.a = bus.ans_dm;
      2'b11:   bus.a = bus.ans_wb;
      default: bus.a = ar;
    endcase

    bus.b = br;
    if (bus.imm_sel) begin
      bus.b = bus.imm;
    end else begin
      unique case (bus.mux_sel_b)
        2'b01:   bus.b = bus.ans_ex;
        2'b10:   bus.b = bus.ans_dm;
        2'b11:   bus.b = bus.ans_wb;
        default: bus.b = br;
      endcase
    end
  end

  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_bank_fwd.sv
module tb_reg_bank_fwd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_fwd_if #(.DATA_W(16), .ADDR_W(5)) bus ();
  reg_bank_fwd_if #(.DATA_W(32), .ADDR_W(3)) bus32 ();

  reg_bank_fwd #(.DATA_W(16), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  reg_bank_fwd #(.DATA_W(32), .ADDR_W(3)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

`ifdef WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: an array of registers plus the two latched operands.
  logic [15:0] mm [32];
  logic [15:0] ar_m, br_m;
  logic        valid_m;

  typedef struct {
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        isel;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } fwd_vec_t;

  fwd_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mm[i] = 16'h0;
    ar_m = 16'h0;
    br_m = 16'h0;
    valid_m = 1'b0;
  endtask

  function automatic logic [15:0] m_read(input logic [4:0] addr);
    if (addr == 5'd0) return 16'h0;
    if (BYPASS && bus.we && bus.rw != 5'd0 && bus.rw == addr) return bus.wdata;
    return mm[addr];
  endfunction

  task automatic model_edge();
    logic [15:0] na, nb;
    na = m_read(bus.ra);
    nb = m_read(bus.rb);
    if (!bus.stall) begin
      ar_m = na;
      br_m = nb;
      valid_m = 1'b1;
    end
    if (bus.we && bus.rw != 5'd0) mm[bus.rw] = bus.wdata;
  endtask

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] lat);
    case (sel)
      2'b01:   return bus.ans_ex;
      2'b10:   return bus.ans_dm;
      2'b11:   return bus.ans_wb;
      default: return lat;
    endcase
  endfunction

  // One clock: model follows the edge, then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_a"}, 32'(bus.a), 32'(pick(bus.mux_sel_a, ar_m)));
    check({tag, "_b"}, 32'(bus.b), 32'(bus.imm_sel ? bus.imm : pick(bus.mux_sel_b, br_m)));
    check({tag, "_vld"}, 32'(bus.rd_valid), 32'(valid_m));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 2'b00, 1'b0, 16'hA5A5, 16'h1234};
    vecs[1] = '{2'b01, 2'b10, 1'b0, 16'h0011, 16'h0022};
    vecs[2] = '{2'b10, 2'b11, 1'b0, 16'h0022, 16'h0033};
    vecs[3] = '{2'b11, 2'b01, 1'b0, 16'h0033, 16'h0011};
    vecs[4] = '{2'b00, 2'b00, 1'b1, 16'hA5A5, 16'h7F00};
    vecs[5] = '{2'b01, 2'b11, 1'b1, 16'h0011, 16'h7F00};

    {bus.ra, bus.rb, bus.rw, bus.wdata, bus.we, bus.stall} = '0;
    {bus.ans_ex, bus.ans_dm, bus.ans_wb, bus.imm} = '0;
    {bus.mux_sel_a, bus.mux_sel_b, bus.imm_sel} = '0;
    {bus32.ra, bus32.rb, bus32.rw, bus32.wdata, bus32.we, bus32.stall} = '0;
    {bus32.ans_ex, bus32.ans_dm, bus32.ans_wb, bus32.imm} = '0;
    {bus32.mux_sel_a, bus32.mux_sel_b, bus32.imm_sel} = '0;
    model_reset();

    // Reset state
    tick();
    tick();
    #1;
    check("rst_a", 32'(bus.a), 32'h0);
    check("rst_b", 32'(bus.b), 32'h0);
    check("rst_vld", 32'(bus.rd_valid), 32'h0);
    rst = 1'b0;

    // Write/read r5, and the 32-bit/3-bit instance at its top address
    bus.we = 1'b1; bus.rw = 5'd5; bus.wdata = 16'h1234;
    bus32.we = 1'b1; bus32.rw = 3'd7; bus32.wdata = 32'hDEADBEEF;
    tick();
    bus.we = 1'b0; bus.ra = 5'd5;
    bus32.we = 1'b0; bus32.ra = 3'd7; bus32.rb = 3'd7;
    tick();
    #1;
    check("wr_r5_a", 32'(bus.a), 32'h1234);
    check("wr_vld", 32'(bus.rd_valid), 32'h1);
    check("p32_a", bus32.a, 32'hDEADBEEF);
    check("p32_b", bus32.b, 32'hDEADBEEF);

    // Writes to r0 are discarded
    bus.we = 1'b1; bus.rw = 5'd0; bus.wdata = 16'hFFFF; bus.ra = 5'd0;
    tick();
    bus.we = 1'b0;
    tick();
    #1;
    check("r0_a", 32'(bus.a), 32'h0);

    // Same-edge read of the write address
    bus.we = 1'b1; bus.rw = 5'd7; bus.wdata = 16'h1111;
    tick();
    bus.wdata = 16'hA5A5; bus.ra = 5'd7;
    tick();
    bus.we = 1'b0;
    #1;
    check("bypass_a", 32'(bus.a), BYPASS ? 32'hA5A5 : 32'h1111);
    tick();
    #1;
    check("bypass_late_a", 32'(bus.a), 32'hA5A5);

    // Forwarding / immediate table with AR=r7, BR=r5
    bus.rb = 5'd5;
    tick();
    bus.ans_ex = 16'h0011; bus.ans_dm = 16'h0022; bus.ans_wb = 16'h0033; bus.imm = 16'h7F00;
    for (int i = 0; i < 6; i++) begin
      bus.mux_sel_a = vecs[i].sa;
      bus.mux_sel_b = vecs[i].sb;
      bus.imm_sel   = vecs[i].isel;
      #1;
      check($sformatf("fwd%0d_a", i), 32'(bus.a), 32'(vecs[i].exp_a));
      check($sformatf("fwd%0d_b", i), 32'(bus.b), 32'(vecs[i].exp_b));
    end
    {bus.mux_sel_a, bus.mux_sel_b, bus.imm_sel} = '0;

    // ra == rb loads the same value
    bus.ra = 5'd5; bus.rb = 5'd5;
    tick();
    #1;
    check("same_a", 32'(bus.a), 32'h1234);
    check("same_b", 32'(bus.b), 32'h1234);

    // Top address r31
    bus.we = 1'b1; bus.rw = 5'd31; bus.wdata = 16'h5A5A;
    tick();
    bus.we = 1'b0; bus.ra = 5'd31;
    tick();
    #1;
    check("top_a", 32'(bus.a), 32'h5A5A);

    // Stall holds latches while the write still lands
    bus.we = 1'b1; bus.rw = 5'd2; bus.wdata = 16'h0002;
    tick();
    bus.we = 1'b0; bus.ra = 5'd2;
    tick();
    #1;
    check("stall_pre_a", 32'(bus.a), 32'h0002);
    bus.stall = 1'b1; bus.we = 1'b1; bus.wdata = 16'h0009;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check($sformatf("stall%0d_a", i), 32'(bus.a), 32'h0002);
    end
    bus.stall = 1'b0; bus.we = 1'b0;
    tick();
    #1;
    check("stall_post_a", 32'(bus.a), 32'h0009);
    check("stall_vld", 32'(bus.rd_valid), 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.ra        = 5'($urandom_range(0, 7));
      bus.rb        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.rw        = ($urandom_range(0, 1) == 0) ? bus.ra : 5'($urandom_range(0, 7));
      bus.wdata     = 16'($urandom);
      bus.we        = 1'($urandom_range(0, 1));
      bus.stall     = ($urandom_range(0, 4) == 0);
      bus.ans_ex    = 16'($urandom);
      bus.ans_dm    = 16'($urandom);
      bus.ans_wb    = 16'($urandom);
      bus.imm       = 16'($urandom);
      bus.mux_sel_a = 2'($urandom);
      bus.mux_sel_b = 2'($urandom);
      bus.imm_sel   = ($urandom_range(0, 3) == 0);
      #1;
      check_model($sformatf("rnd%0d", n));
      tick();
    end
    {bus.mux_sel_a, bus.mux_sel_b, bus.imm_sel, bus.stall} = '0;

    // Mid-run reset clears the array immediately and beats a same-edge write
    bus.we = 1'b1; bus.rw = 5'd3; bus.wdata = 16'hBEEF; bus.ra = 5'd3;
    tick();
    bus.we = 1'b0;
    tick();
    #1;
    check("pre_rst_a", 32'(bus.a), 32'hBEEF);
    rst = 1'b1;
    bus.we = 1'b1; bus.rw = 5'd4; bus.wdata = 16'h4444;
    #1;
    check("mid_rst_a", 32'(bus.a), 32'h0);
    check("mid_rst_b", 32'(bus.b), 32'h0);
    check("mid_rst_vld", 32'(bus.rd_valid), 32'h0);
    check("mid_rst_p32_a", bus32.a, 32'h0);
    tick();
    rst = 1'b0;
    bus.we = 1'b0; bus.ra = 5'd3; bus.rb = 5'd4;
    tick();
    #1;
    check("post_rst_r3", 32'(bus.a), 32'h0);
    check("post_rst_r4", 32'(bus.b), 32'h0);
    check("post_rst_vld", 32'(bus.rd_valid), 32'h1);
    check_model("post_rst_model");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
